// File: rtl/jtag_tap_controller_if.sv
// JTAG TAP pin and chain-side signal bundle; clock and reset stay outside.
// The slave modport is the TAP controller, the master modport the pin/chain driver.
interface jtag_tap_controller_if #(
    parameter int IR_WIDTH = 5
);
    logic                io_tms;
    logic                io_tdi;
    logic                io_tdo;
    logic                io_tdo_en;
    logic                io_chainOut_capture;
    logic                io_chainOut_shift;
    logic                io_chainOut_update;
    logic                io_chainOut_data;
    logic                io_chainIn_data;
    logic [IR_WIDTH-1:0] io_ir;
    logic [3:0]          io_state;
    logic                io_tlr;

    modport master (
        output io_tms, io_tdi, io_chainIn_data,
        input  io_tdo, io_tdo_en, io_chainOut_capture, io_chainOut_shift,
               io_chainOut_update, io_chainOut_data, io_ir, io_state, io_tlr
    );

    modport slave (
        input  io_tms, io_tdi, io_chainIn_data,
        output io_tdo, io_tdo_en, io_chainOut_capture, io_chainOut_shift,
               io_chainOut_update, io_chainOut_data, io_ir, io_state, io_tlr
    );
endinterface

// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state FSM, instruction register, bypass
// register and capture/shift/update strobes for the selected data chain.
module jtag_tap_controller #(
    parameter int                  IR_WIDTH     = 5,
    parameter logic [IR_WIDTH-1:0] IDCODE_INSTR = IR_WIDTH'(5'h01),
    parameter logic [IR_WIDTH-1:0] BYPASS_INSTR = {IR_WIDTH{1'b1}}
) (
    input  logic                clock,
    input  logic                reset,
    jtag_tap_controller_if.slave tap
);

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET = 4'd15,
        RUN_TEST_IDLE    = 4'd12,
        SELECT_DR        = 4'd7,
        CAPTURE_DR       = 4'd6,
        SHIFT_DR         = 4'd2,
        EXIT1_DR         = 4'd1,
        PAUSE_DR         = 4'd3,
        EXIT2_DR         = 4'd0,
        UPDATE_DR        = 4'd5,
        SELECT_IR        = 4'd4,
        CAPTURE_IR       = 4'd14,
        SHIFT_IR         = 4'd10,
        EXIT1_IR         = 4'd9,
        PAUSE_IR         = 4'd11,
        EXIT2_IR         = 4'd8,
        UPDATE_IR        = 4'd13
    } tap_state_e;

    tap_state_e          state_r;
    tap_state_e          next_state_s;
    logic [IR_WIDTH-1:0] ir_shift_r;
    logic [IR_WIDTH-1:0] ir_r;
    logic                bypass_r;
    logic                bypass_sel_s;
    logic                capture_s;
    logic                shift_s;
    logic                update_s;
    logic                tdo_s;
    logic                tdo_en_s;
    logic                tlr_s;

    assign bypass_sel_s = (ir_r == BYPASS_INSTR);

    // TAP state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= TEST_LOGIC_RESET;
        end else begin
            state_r <= next_state_s;
        end
    end

    // TAP next-state decode on TMS
    always_comb begin
        next_state_s = TEST_LOGIC_RESET;
        case (state_r)
            TEST_LOGIC_RESET: next_state_s = tap.io_tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    next_state_s = tap.io_tms ? SELECT_DR        : RUN_TEST_IDLE;
            SELECT_DR:        next_state_s = tap.io_tms ? SELECT_IR        : CAPTURE_DR;
            CAPTURE_DR:       next_state_s = tap.io_tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         next_state_s = tap.io_tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         next_state_s = tap.io_tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         next_state_s = tap.io_tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         next_state_s = tap.io_tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        next_state_s = tap.io_tms ? SELECT_DR        : RUN_TEST_IDLE;
            SELECT_IR:        next_state_s = tap.io_tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       next_state_s = tap.io_tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         next_state_s = tap.io_tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         next_state_s = tap.io_tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         next_state_s = tap.io_tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         next_state_s = tap.io_tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        next_state_s = tap.io_tms ? SELECT_DR        : RUN_TEST_IDLE;
            default:          next_state_s = TEST_LOGIC_RESET;
        endcase
    end

    // Strobe and TDO decode; a single case on the state keeps the strobes exclusive
    always_comb begin
        capture_s = 1'b0;
        shift_s   = 1'b0;
        update_s  = 1'b0;
        tdo_s     = 1'b0;
        tdo_en_s  = 1'b0;
        tlr_s     = 1'b0;
        case (state_r)
            TEST_LOGIC_RESET: tlr_s = 1'b1;
            CAPTURE_DR:       capture_s = 1'b1;
            SHIFT_DR: begin
                shift_s  = 1'b1;
                tdo_en_s = 1'b1;
                tdo_s    = bypass_sel_s ? bypass_r : tap.io_chainIn_data;
            end
            UPDATE_DR:        update_s = 1'b1;
            SHIFT_IR: begin
                tdo_en_s = 1'b1;
                tdo_s    = ir_shift_r[0];
            end
            default:          tdo_s = 1'b0;
        endcase
    end

    // IR shift register: capture fixed 0..01 pattern, shift TDI in at the MSB
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ir_shift_r <= '0;
        end else if (state_r == CAPTURE_IR) begin
            ir_shift_r <= IR_WIDTH'(2'b01);
        end else if (state_r == SHIFT_IR) begin
            ir_shift_r <= {tap.io_tdi, ir_shift_r[IR_WIDTH-1:1]};
        end else begin
            ir_shift_r <= ir_shift_r;
        end
    end

    // Active instruction: IDCODE whenever TLR is (re)entered, else latched in Update-IR
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ir_r <= IDCODE_INSTR;
        end else if (next_state_s == TEST_LOGIC_RESET) begin
            ir_r <= IDCODE_INSTR;
        end else if (state_r == UPDATE_IR) begin
            ir_r <= ir_shift_r;
        end else begin
            ir_r <= ir_r;
        end
    end

    // Single-bit bypass register, only active when BYPASS is the instruction
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bypass_r <= 1'b0;
        end else if (bypass_sel_s && (state_r == CAPTURE_DR)) begin
            bypass_r <= 1'b0;
        end else if (bypass_sel_s && (state_r == SHIFT_DR)) begin
            bypass_r <= tap.io_tdi;
        end else begin
            bypass_r <= bypass_r;
        end
    end

    assign tap.io_tdo              = tdo_s;
    assign tap.io_tdo_en           = tdo_en_s;
    assign tap.io_chainOut_capture = capture_s;
    assign tap.io_chainOut_shift   = shift_s;
    assign tap.io_chainOut_update  = update_s;
    assign tap.io_chainOut_data    = tap.io_tdi;
    assign tap.io_ir               = ir_r;
    assign tap.io_state            = state_r;
    assign tap.io_tlr              = tlr_s;

endmodule
